// File: rtl/el2_ifu_compress_pack.sv
// el2_ifu_compress_pack
// Rewrites a subset of RV32I instructions into 16-bit RVC form. It then packs
// the resulting 16/32-bit parcels into halfword-aligned 32-bit fetch words.
// The IFU aligner/expander can consume those words directly.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmp_en          1 = compress eligible instructions, 0 = pass all as 32-bit
//   in_valid/ready  instruction input handshake, in_instr = 32-bit instruction
//   flush           drain a pending halfword, padded with C.NOP (16'h0001)
//   out_valid/ready packed word handshake, out_data low half = earlier parcel
//   flush_done      one-cycle pulse per flush assertion once the drain completes
//   cmp_cnt         saturating count of compressed instructions accepted
module el2_ifu_compress_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             flush_done,
  output logic [CNT_W-1:0] cmp_cnt
);

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             hold_vld_q, hold_vld_d;
  logic [15:0]      hold_data_q, hold_data_d;
  logic             flush_done_q, flush_done_d;
  logic             flush_ack_q, flush_ack_d;
  logic [CNT_W-1:0] cmp_cnt_q, cmp_cnt_d;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] i_imm, s_imm;
  logic [20:0] j_off;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];
  assign i_imm  = in_instr[31:20];
  assign s_imm  = {in_instr[31:25], in_instr[11:7]};
  assign j_off  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  logic is_add, is_addi, is_lw, is_sw, is_jal;
  logic imm6_ok, lw_off_ok, sw_off_ok, j_off_ok;
  logic rd_c, rs1_c, rs2_c;

  assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_jal  = (opcode == 7'b1101111);

  // Sign-extended immediate fits in 6 bits when bits [11:5] are all equal
  assign imm6_ok   = (i_imm[11:5] == 7'h00) || (i_imm[11:5] == 7'h7f);
  // Word offsets 0..124: unsigned, 7 significant bits, word aligned
  assign lw_off_ok = (i_imm[11:7] == 5'd0) && (i_imm[1:0] == 2'b00);
  assign sw_off_ok = (s_imm[11:7] == 5'd0) && (s_imm[1:0] == 2'b00);
  // Jump offset fits in 12-bit signed range when bits [20:11] are all equal
  assign j_off_ok  = (j_off[20:11] == 10'h000) || (j_off[20:11] == 10'h3ff);

  // Compressed register fields address x8..x15 only
  assign rd_c  = (rd[4:3]  == 2'b01);
  assign rs1_c = (rs1[4:3] == 2'b01);
  assign rs2_c = (rs2[4:3] == 2'b01);

  logic        c_hit;
  logic [15:0] c_instr;

  always_comb begin
    c_hit   = 1'b0;
    c_instr = 16'h0000;
    if (cmp_en && (in_instr[1:0] == 2'b11)) begin
      if (is_add && (rs1 == 5'd0) && (rd != 5'd0) && (rs2 != 5'd0)) begin
        c_hit   = 1'b1;
        c_instr = {3'b100, 1'b0, rd, rs2, 2'b10};
      end else if (is_add && (rs1 == rd) && (rd != 5'd0) && (rs2 != 5'd0)) begin
        c_hit   = 1'b1;
        c_instr = {3'b100, 1'b1, rd, rs2, 2'b10};
      end else if (is_addi && (rs1 == 5'd0) && (rd != 5'd0) && imm6_ok) begin
        c_hit   = 1'b1;
        c_instr = {3'b010, i_imm[5], rd, i_imm[4:0], 2'b01};
      end else if (is_addi && (rs1 == rd) && (rd != 5'd0) && (i_imm != 12'd0) && imm6_ok) begin
        c_hit   = 1'b1;
        c_instr = {3'b000, i_imm[5], rd, i_imm[4:0], 2'b01};
      end else if (is_lw && rd_c && rs1_c && lw_off_ok) begin
        c_hit   = 1'b1;
        c_instr = {3'b010, i_imm[5:3], rs1[2:0], i_imm[2], i_imm[6], rd[2:0], 2'b00};
      end else if (is_sw && rs2_c && rs1_c && sw_off_ok) begin
        c_hit   = 1'b1;
        c_instr = {3'b110, s_imm[5:3], rs1[2:0], s_imm[2], s_imm[6], rs2[2:0], 2'b00};
      end else if (is_jal && (rd == 5'd0) && j_off_ok) begin
        c_hit   = 1'b1;
        c_instr = {3'b101, j_off[11], j_off[4], j_off[9:8], j_off[10], j_off[6],
                   j_off[7], j_off[3:1], j_off[5], 2'b01};
      end
    end
  end

  logic slot_free, accept;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !flush && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    flush_ack_d  = flush_ack_q;
    flush_done_d = 1'b0;
    cmp_cnt_d    = cmp_cnt_q;

    if (out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (c_hit && (cmp_cnt_q != {CNT_W{1'b1}})) cmp_cnt_d = cmp_cnt_q + 1'b1;
      if (!hold_vld_q) begin
        if (c_hit) begin
          hold_vld_d  = 1'b1;
          hold_data_d = c_instr;
        end else begin
          out_data_d  = in_instr;
          out_valid_d = 1'b1;
        end
      end else if (c_hit) begin
        out_data_d  = {c_instr, hold_data_q};
        out_valid_d = 1'b1;
        hold_vld_d  = 1'b0;
      end else begin
        // Straddle: the upper half of the instruction becomes the new pending halfword
        out_data_d  = {in_instr[15:0], hold_data_q};
        out_valid_d = 1'b1;
        hold_data_d = in_instr[31:16];
      end
    end

    // flush_ack_q remembers that this flush assertion has already been serviced
    if (flush && !flush_ack_q && slot_free) begin
      flush_ack_d  = 1'b1;
      flush_done_d = 1'b1;
      if (hold_vld_q) begin
        out_data_d  = {16'h0001, hold_data_q};
        out_valid_d = 1'b1;
        hold_vld_d  = 1'b0;
      end
    end
    if (!flush) flush_ack_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= 16'h0;
      flush_done_q <= 1'b0;
      flush_ack_q  <= 1'b0;
      cmp_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      flush_done_q <= flush_done_d;
      flush_ack_q  <= flush_ack_d;
      cmp_cnt_q    <= cmp_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign flush_done = flush_done_q;
  assign cmp_cnt    = cmp_cnt_q;

endmodule

// File: tb/tb_el2_ifu_compress_pack.sv
// Directed testbench for el2_ifu_compress_pack with hand-computed expectations.
module tb_el2_ifu_compress_pack;

  logic        clk = 1'b0;
  logic        rst, cmp_en, in_valid, in_ready, flush, out_valid, out_ready, flush_done;
  logic [31:0] in_instr, out_data;
  logic [15:0] cmp_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  el2_ifu_compress_pack #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmp_en(cmp_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush_done(flush_done), .cmp_cnt(cmp_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1; cmp_en = 1'b1; in_valid = 1'b0; in_instr = 32'h0;
    flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_cmp_cnt", {16'd0, cmp_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Hold pair: C.ADDI then C.ADD
    send(32'h00550513);
    check("t1_no_out", {31'd0, out_valid}, 32'd0);
    check("t1_cnt1", {16'd0, cmp_cnt}, 32'd1);
    send(32'h00B50533);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", out_data, 32'h952E0515);
    check("t1_cnt2", {16'd0, cmp_cnt}, 32'd2);
    step();
    check("t1_taken", {31'd0, out_valid}, 32'd0);

    // Straddle then flush
    send(32'h00550513);
    send(32'h123452B7);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_data", out_data, 32'h52B70515);
    check("t2_cnt", {16'd0, cmp_cnt}, 32'd3);
    flush = 1'b1;
    #1;
    check("t2_flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("t2_flush_data", out_data, 32'h00011234);
    check("t2_flush_valid", {31'd0, out_valid}, 32'd1);
    check("t2_flush_done", {31'd0, flush_done}, 32'd1);
    step();
    check("t2_flush_done_once", {31'd0, flush_done}, 32'd0);
    check("t2_flush_taken", {31'd0, out_valid}, 32'd0);
    step();
    check("t2_flush_done_still0", {31'd0, flush_done}, 32'd0);
    flush = 1'b0;
    step();

    // Immediate boundaries
    send(32'hFE050513);
    check("t3_m32_no_out", {31'd0, out_valid}, 32'd0);
    check("t3_cnt", {16'd0, cmp_cnt}, 32'd4);
    send(32'h02050513);
    check("t3_p32_data", out_data, 32'h05131501);
    send(32'h00050513);
    check("t3_zero_data", out_data, 32'h05130205);
    check("t3_cnt_same", {16'd0, cmp_cnt}, 32'd4);
    flush = 1'b1;
    step();
    check("t3_flush_data", out_data, 32'h00010005);
    check("t3_flush_done", {31'd0, flush_done}, 32'd1);
    flush = 1'b0;
    step();

    // Other compressed forms: C.LI + C.MV, C.LW + C.SW, C.J + C.ADDI
    send(32'hFFF00513);
    send(32'h00B00533);
    check("t3_li_mv", out_data, 32'h852E557D);
    send(32'h00442483);
    send(32'h00942423);
    check("t3_lw_sw", out_data, 32'hC4044044);
    send(32'hFFFFF06F);
    send(32'h00550513);
    check("t3_j_addi", out_data, 32'h0515BFFD);
    check("t3_cnt_forms", {16'd0, cmp_cnt}, 32'd10);
    step();

    // cmp_en = 0 from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp_en = 1'b0;
    send(32'h00550513);
    check("t4_word0", out_data, 32'h00550513);
    check("t4_valid0", {31'd0, out_valid}, 32'd1);
    send(32'h00B50533);
    check("t4_word1", out_data, 32'h00B50533);
    check("t4_cnt", {16'd0, cmp_cnt}, 32'd0);
    step();
    cmp_en = 1'b1;

    // Backpressure
    out_ready = 1'b0;
    send(32'h123452B7);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    held = out_data;
    check("t5_data", held, 32'h123452B7);
    in_valid = 1'b1;
    in_instr = 32'h00000013;
    for (int i = 0; i < 5; i++) begin
      check("t5_bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("t5_bp_stable", out_data, 32'h123452B7);
      check("t5_bp_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("t5_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("t5_next_word", out_data, 32'h00000013);
    check("t5_next_valid", {31'd0, out_valid}, 32'd1);
    step();
    check("t5_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with a pending halfword and an unconsumed word
    send(32'h00550513);
    out_ready = 1'b0;
    send(32'h123452B7);
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_cnt", {16'd0, cmp_cnt}, 32'd0);
    check("t6_rst_data", out_data, 32'h0);
    out_ready = 1'b1;
    send(32'h123452B7);
    check("t6_direct", out_data, 32'h123452B7);
    check("t6_direct_valid", {31'd0, out_valid}, 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
